outfifo_unloader: RTL
=====================

# outfifo_unloader

Read-side drain engine for the 48-bit DAQ/trigger output FIFO. It pops 48-bit entries from the FIFO read port and sends each entry downstream as three 16-bit slices over a valid/ready link, most significant slice first. It flags the first and last slice of each entry and keeps a saturating count of completed entries. It runs entirely in the FIFO read clock domain.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  FIFO read clock; the only clock in the block.
- `rst_n`  in  1  asynchronous active-low reset.
- `fifo_dout`  in  48  FIFO read data; valid one cycle after `fifo_rden` (standard, non-FWFT FIFO).
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rden`  out  1  FIFO read enable, registered, one-cycle pulse per entry.
- `daq_data`  out  16  slice data, registered.
- `daq_valid`  out  1  slice valid.
- `daq_ready`  in  1  downstream accepts the slice this cycle.
- `daq_first`  out  1  current slice is bits [47:32].
- `daq_last`  out  1  current slice is bits [15:0].
- `daq_par`  out  1  slice parity (see Configuration).
- `cnt_clr`  in  1  synchronous clear of `words_sent`.
- `words_sent`  out  16  number of completed entries, saturating.

## Operation
- States: IDLE, RD, CAP, S0, S1, S2.
- IDLE: if `fifo_empty`=0, go to RD.
- RD: `fifo_rden`=1 for exactly this cycle, then go to CAP.
- CAP: latch `fifo_dout` into a 48-bit hold register at the clock edge, then go to S0.
- S0: `daq_valid`=1, `daq_data`=hold[47:32], `daq_first`=1.
- S1: `daq_valid`=1, `daq_data`=hold[31:16].
- S2: `daq_valid`=1, `daq_data`=hold[15:0], `daq_last`=1.
- A slice transfers on an edge where `daq_valid` and `daq_ready` are both 1. Sn then advances to Sn+1.
- While `daq_ready`=0, the block holds its state. `daq_data`, `daq_first`, `daq_last` and `daq_par` stay stable.
- When S2 transfers:
  - `words_sent` increments, unless it is already 0xFFFF.
  - The next state is RD if `fifo_empty`=0, otherwise IDLE.
- `fifo_empty` is sampled only in IDLE and on the S2 transfer edge. It is ignored in all other states.
- `fifo_rden` is never asserted while `fifo_empty`=1, and never twice for one entry.
- `cnt_clr` has priority over an increment on the same edge. The result is 0.
- Reset value of every output is 0: `fifo_rden`, `daq_data`, `daq_valid`, `daq_first`, `daq_last`, `daq_par`, `words_sent`. The state after reset is IDLE.
- Reset mid-entry abandons the entry. Its remaining slices are not sent and the counter does not increment. Any entry that was popped is lost.

## Timing
- Latency from `fifo_empty` falling while in IDLE:
  - cycle +1: RD, `fifo_rden`=1.
  - cycle +2: CAP.
  - cycle +3: S0, `daq_valid`=1.
- With `daq_ready` held at 1, one entry takes 3 cycles on the link. Back-to-back entries go S2 → RD → CAP → S0, which leaves a 2-cycle gap between entries. Sustained rate is 3 slices per 5 cycles.
- All outputs are registered. There is no combinational path from `daq_ready` or `fifo_empty` to any output.
- `words_sent` updates on the S2 transfer edge and is visible the cycle after.

## Configuration
- `OUTFIFO_UNLOADER_PARITY_EN` defined: `daq_par` is registered odd parity of `daq_data`, so XOR of `daq_data` and `daq_par` equals 1. It is updated together with `daq_data`.
- `OUTFIFO_UNLOADER_PARITY_EN` undefined: `daq_par` is tied to 0, no parity logic is built, and the port is kept.

## Test plan
- Reset with `fifo_empty`=1 → all outputs 0 and `fifo_rden` never asserts over 100 cycles.
- One entry 0x123456789ABC with `daq_ready`=1:
  - slices, in order: 0x1234 (`daq_first`=1), 0x5678, 0x9ABC (`daq_last`=1);
  - first `daq_valid` 3 cycles after `fifo_empty` falls;
  - exactly one `fifo_rden` pulse;
  - `words_sent`=1.
- Backpressure: `daq_ready` low for 4 cycles during S1 → `daq_data` holds 0x5678 for those cycles, and no slice is duplicated or lost.
- Three queued entries with `daq_ready`=1 → 9 slices in FIFO order, 2-cycle gaps between entries, `words_sent`=3, return to IDLE when `fifo_empty`=1.
- Counter preset to 0xFFFE, then two entries → `words_sent` stays at 0xFFFF. Then `cnt_clr` together with an S2 transfer → `words_sent`=0.
- `rst_n` pulsed low during S1 → outputs 0 at once. After release, the next entry starts cleanly at S0.
- With the parity macro defined, slice 0x0001 → `daq_par`=0.

Source files
------------

// File: rtl/outfifo_unloader.sv
// -----------------------------------------------------------------------------
// outfifo_unloader
//
// Read-side drain engine for the 48-bit DAQ/trigger output FIFO. Pops one
// entry at a time from a standard (non-FWFT) FIFO and streams it downstream
// as three 16-bit slices, most significant slice first, over a valid/ready
// link. Keeps a saturating count of fully sent entries.
//
// Ports:
//   clk         FIFO read clock (only clock)
//   rst_n       asynchronous active-low reset
//   fifo_dout   FIFO read data, valid the cycle after fifo_rden
//   fifo_empty  FIFO empty flag
//   fifo_rden   FIFO read enable, registered one-cycle pulse per entry
//   daq_data    slice data (registered)
//   daq_valid   slice valid (registered)
//   daq_ready   downstream accepts the slice this cycle
//   daq_first   slice is bits [47:32] of the entry
//   daq_last    slice is bits [15:0] of the entry
//   daq_par     odd parity of daq_data when enabled, else 0
//   cnt_clr     synchronous clear of words_sent (wins over increment)
//   words_sent  completed-entry count, saturates at 16'hFFFF
//
// Handshake: a slice transfers on a rising edge where daq_valid and
// daq_ready are both 1. While daq_valid=1 and daq_ready=0 the slice and its
// flags are held unchanged; daq_valid never drops without a transfer.
//
// Optional feature: define OUTFIFO_UNLOADER_PARITY_EN to build the
// registered odd-parity generator for daq_par.
// -----------------------------------------------------------------------------
module outfifo_unloader (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [47:0] fifo_dout,
   input  logic        fifo_empty,
   output logic        fifo_rden,
   output logic [15:0] daq_data,
   output logic        daq_valid,
   input  logic        daq_ready,
   output logic        daq_first,
   output logic        daq_last,
   output logic        daq_par,
   input  logic        cnt_clr,
   output logic [15:0] words_sent
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CAP  = 3'd2,
      ST_S0   = 3'd3,
      ST_S1   = 3'd4,
      ST_S2   = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [47:0] r_hold;
   logic [47:0] w_hold_next;
   logic [15:0] r_words_sent;
   logic [15:0] w_words_next;
   logic        r_rden;
   logic [15:0] r_daq_data;
   logic        r_daq_valid;
   logic        r_daq_first;
   logic        r_daq_last;
   logic [15:0] w_data_next;
   logic        w_xfer;

   // Next-state, hold register and counter logic.
   always_comb begin
      w_state_next = r_state;
      w_hold_next  = r_hold;
      w_words_next = r_words_sent;
      w_xfer       = r_daq_valid & daq_ready;
      case (r_state)
         ST_IDLE: if (!fifo_empty) w_state_next = ST_RD;
         ST_RD:   w_state_next = ST_CAP;
         ST_CAP: begin
            // Non-FWFT FIFO: data appears the cycle after the read pulse.
            w_hold_next  = fifo_dout;
            w_state_next = ST_S0;
         end
         ST_S0:   if (w_xfer) w_state_next = ST_S1;
         ST_S1:   if (w_xfer) w_state_next = ST_S2;
         ST_S2: begin
            if (w_xfer) begin
               w_state_next = fifo_empty ? ST_IDLE : ST_RD;
               if (r_words_sent != 16'hFFFF) w_words_next = r_words_sent + 16'd1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
      if (cnt_clr) w_words_next = 16'h0000;
   end

   // Outputs are registered from the next state so they line up with it;
   // CAP->S0 uses the hold value being latched on that same edge.
   always_comb begin
      w_data_next = r_daq_data;
      case (w_state_next)
         ST_S0:   w_data_next = w_hold_next[47:32];
         ST_S1:   w_data_next = w_hold_next[31:16];
         ST_S2:   w_data_next = w_hold_next[15:0];
         default: w_data_next = r_daq_data;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_hold       <= 48'h0;
         r_words_sent <= 16'h0;
         r_rden       <= 1'b0;
         r_daq_data   <= 16'h0;
         r_daq_valid  <= 1'b0;
         r_daq_first  <= 1'b0;
         r_daq_last   <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_hold       <= w_hold_next;
         r_words_sent <= w_words_next;
         r_rden       <= (w_state_next == ST_RD);
         r_daq_data   <= w_data_next;
         r_daq_valid  <= (w_state_next == ST_S0) || (w_state_next == ST_S1) ||
                         (w_state_next == ST_S2);
         r_daq_first  <= (w_state_next == ST_S0);
         r_daq_last   <= (w_state_next == ST_S2);
      end
   end

`ifdef OUTFIFO_UNLOADER_PARITY_EN
   logic r_par;

   // Odd parity: XOR over {daq_data, daq_par} is always 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_par <= 1'b0;
      else        r_par <= ~(^w_data_next);
   end

   assign daq_par = r_par;
`else
   assign daq_par = 1'b0;
`endif

   assign fifo_rden  = r_rden;
   assign daq_data   = r_daq_data;
   assign daq_valid  = r_daq_valid;
   assign daq_first  = r_daq_first;
   assign daq_last   = r_daq_last;
   assign words_sent = r_words_sent;

endmodule
